// File: rtl/ram_memory_pkg.sv
// Shared geometry and word/address types for the 64 x 4 single-port scratch RAM.
package ram_memory_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage : ram_memory_pkg

// File: rtl/ram_memory.sv
// Single-port synchronous RAM: Enable-gated write or 1-cycle registered read on the
// shared Address bus; asynchronous reset clears every word and the read register.
module ram_memory
  import ram_memory_pkg::*;
#(
  parameter data_t INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataOut
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;
  logic              wr_en_s;
  logic              rd_en_s;

  // Decode the access and hold DataOut unless a read is performed (no write-through).
  always_comb begin
    wr_en_s    = Enable & ReadWrite;
    rd_en_s    = Enable & ~ReadWrite;
    data_out_d = data_out_q;
    if (rd_en_s) begin
      data_out_d = mem_q[Address];
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Storage array and read register; reset wins over any access sampled with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT_VAL;
      end
      data_out_q <= INIT_VAL;
    end else begin
      if (wr_en_s) begin
        mem_q[Address] <= DataIn;
      end
      data_out_q <= data_out_d;
    end
  end

  assign DataOut = data_out_q;

endmodule : ram_memory

// File: tb/tb_ram_memory.sv
// Self-checking bench for ram_memory: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an array-based model.
module tb_ram_memory;
  import ram_memory_pkg::*;

  logic  clk       = 1'b0;
  logic  rst_n     = 1'b1;
  logic  Enable    = 1'b0;
  logic  ReadWrite = 1'b0;
  data_t DataIn    = 4'h0;
  addr_t Address   = 6'h00;
  data_t DataOut;

  int vectors     = 0;
  int miscompares = 0;

  data_t model_mem [DEPTH];
  data_t model_out;

  always #5 clk = ~clk;

  ram_memory dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Enable    (Enable),
    .ReadWrite (ReadWrite),
    .DataIn    (DataIn),
    .Address   (Address),
    .DataOut   (DataOut)
  );

  task automatic check(input string name, input data_t act, input data_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: DataOut=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference behaviour: an array of words, a read register, reset clears both.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] <= 4'h0;
      model_out <= 4'h0;
    end else if (Enable) begin
      if (ReadWrite) model_mem[Address] <= DataIn;
      else           model_out <= model_mem[Address];
    end
  end

  // Every negedge the registered output must equal the model.
  always @(negedge clk) begin
    check("model", DataOut, model_out);
  end

  // Apply one access and return 1 time unit after the edge that sampled it.
  task automatic cyc(input logic en, input logic rw, input data_t d, input addr_t a);
    Enable    = en;
    ReadWrite = rw;
    DataIn    = d;
    Address   = a;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle reset pulse spanning one clock edge; the access pending at that edge is dropped.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 check("rst_async", DataOut, 4'h0);
    @(negedge clk);
    @(posedge clk);
    #1 Enable = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    data_t exp;

    // 1. reset and reads of never-written words
    reset_pulse();
    cyc(1'b1, 1'b0, 4'h0, 6'h00); check("rst_rd0",  DataOut, 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 6'h1F); check("rst_rd31", DataOut, 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 6'h3F); check("rst_rd63", DataOut, 4'h0);

    // 2. write / readback
    cyc(1'b1, 1'b1, 4'hA, 6'h05);
    cyc(1'b1, 1'b1, 4'h3, 6'h3F); check("wr_hold", DataOut, 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 6'h05); check("rd05", DataOut, 4'hA);
    cyc(1'b1, 1'b0, 4'h0, 6'h3F); check("rd3F", DataOut, 4'h3);

    // 3. enable gating
    cyc(1'b0, 1'b1, 4'hF, 6'h05); check("idle_wr_hold", DataOut, 4'h3);
    cyc(1'b0, 1'b0, 4'hF, 6'h05); check("idle_rd_hold", DataOut, 4'h3);
    cyc(1'b1, 1'b0, 4'h0, 6'h05); check("gated_mem5", DataOut, 4'hA);

    // 4. no write-through
    cyc(1'b1, 1'b1, 4'h7, 6'h05); check("no_wt", DataOut, 4'hA);
    cyc(1'b1, 1'b0, 4'h0, 6'h05); check("rd_new", DataOut, 4'h7);

    // 6. reset in the middle of a back-to-back write sweep
    for (int i = 0; i < 40; i++) begin
      exp = data_t'(i) ^ 4'hA;
      if (i == 30) begin
        Enable = 1'b1; ReadWrite = 1'b1; DataIn = exp; Address = addr_t'(i);
        reset_pulse();
      end else begin
        cyc(1'b1, 1'b1, exp, addr_t'(i));
      end
    end
    cyc(1'b1, 1'b0, 4'h0, 6'h10); check("mid_rst_rd10", DataOut, 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 6'h3F); check("mid_rst_rd3F", DataOut, 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 6'h1E); check("mid_rst_dropped", DataOut, 4'h0);

    // 5. full sweep, writes then reads, no bubbles
    for (int i = 0; i < DEPTH; i++) begin
      exp = data_t'(i) ^ 4'h5;
      cyc(1'b1, 1'b1, exp, addr_t'(i));
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = data_t'(i) ^ 4'h5;
      cyc(1'b1, 1'b0, 4'h0, addr_t'(i));
      check("sweep_rd", DataOut, exp);
    end

    // randomized traffic with corner-biased addresses and occasional resets
    for (int n = 0; n < 600; n++) begin
      addr_t a;
      if (n % 150 == 149) begin
        Enable = 1'b1; ReadWrite = 1'($urandom_range(0, 1));
        reset_pulse();
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 6'h00;
          1:       a = 6'h3F;
          default: a = addr_t'($urandom_range(0, DEPTH - 1));
        endcase
        cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            data_t'($urandom_range(0, 15)), a);
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ram_memory
